// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampled UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam int MID_TICK  = 7;
  localparam int LAST_TICK = 15;

  // Tick counter must hold both LAST_TICK and SB_TICK-1.
  function automatic int s_width(input int sb_tick);
    return ($clog2(sb_tick) > 4) ? $clog2(sb_tick) : 4;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and oversample tick in, frame result out.
// parity_err is present only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(parameter int DBIT = 8);
  logic            rx;
  logic            s_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;
`endif

`ifdef UART_RX_PARITY_EN
  modport master (output rx, s_tick, input rx_done_tick, dout, parity_err);
  modport slave  (input rx, s_tick, output rx_done_tick, dout, parity_err);
`else
  modport master (output rx, s_tick, input rx_done_tick, dout);
  modport slave  (input rx, s_tick, output rx_done_tick, dout);
`endif
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; RST_VAL sets the reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver, LSB first, 16x oversampling via s_tick; rx passes a 2-flop synchroniser.
// Optional even-parity stage built in when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);
  localparam int SW = s_width(SB_TICK);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_LAST = SW'(LAST_TICK);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic [DBIT-1:0] dout_r;
  logic            done_r;
  logic            rx_s;
`ifdef UART_RX_PARITY_EN
  logic            pbit;
  logic            perr_r;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      dout_r <= '0;
      done_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit   <= 1'b0;
      perr_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (s_tick_q()) begin
            if (s == S_MID) begin
              // A line that is high again at mid start bit was only a glitch.
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick_q()) begin
            if (s == S_LAST) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick_q()) begin
            if (s == S_LAST) begin
              pbit  <= rx_s;
              s     <= '0;
              state <= STOP;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (s_tick_q()) begin
            if (s == S_STOP) begin
              state  <= IDLE;
              done_r <= 1'b1;
              dout_r <= b;
`ifdef UART_RX_PARITY_EN
              perr_r <= (^b) ^ pbit;
`endif
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic s_tick_q();
    return bus.s_tick;
  endfunction

  assign bus.rx_done_tick = done_r;
  assign bus.dout         = dout_r;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_r;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames, hand-written corner sequences, random frames vs a frame-level model.
module tb_uart_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  uart_rx_if #(.DBIT(8)) ifc ();
  uart_rx_if #(.DBIT(8)) ifc32 ();

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut   (.clk(clk), .reset(reset), .bus(ifc.slave));
  uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (.clk(clk), .reset(reset), .bus(ifc32.slave));

  assign ifc32.rx     = ifc.rx;
  assign ifc32.s_tick = ifc.s_tick;

`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Start edge to done: 8 ticks to mid start bit, 16 per data/parity bit, 16 in stop.
  localparam int FRAME_TICKS = 8 + (8 + PB) * 16 + 16;
  localparam int LAT_LO = (FRAME_TICKS - 2) * 10;
  localparam int LAT_HI = (FRAME_TICKS + 16) * 10;

  typedef struct {
    logic [7:0] d;
    logic       perr;
    int         cyc;
  } rec_t;

  typedef struct {
    logic [7:0] d;
    logic       pbit;
    int         gap;
    logic [7:0] exp_dout;
    logic       exp_perr;
  } vec_t;

  rec_t       rcv[$];
  int         q32_cyc[$];
  logic [7:0] q32_d[$];
  logic       prev_done = 1'b0;
  logic [7:0] held = 8'h00;
  int         wide = 0;
  int         hold_viol = 0;

  // 100 MHz clock, one s_tick every 10 clk.
  initial begin
    ifc.s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ifc.s_tick = (cyc % 10 == 0);
    end
  end

  always @(negedge clk) begin
    rec_t r;
    if (reset) begin
      prev_done = 1'b0;
      held      = 8'h00;
    end else begin
      if (ifc.rx_done_tick) begin
        r.d = ifc.dout;
`ifdef UART_RX_PARITY_EN
        r.perr = ifc.parity_err;
`else
        r.perr = 1'b0;
`endif
        r.cyc = cyc;
        rcv.push_back(r);
        if (prev_done) wide++;
        held = ifc.dout;
      end else if (ifc.dout !== held) begin
        hold_viol++;
      end
      prev_done = ifc.rx_done_tick;
      if (ifc32.rx_done_tick) begin
        q32_cyc.push_back(cyc);
        q32_d.push_back(ifc32.dout);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    compared++;
    if (act < lo || act > hi) begin
      mismatched++;
      $display("FAIL %s: got %0d expected in [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Put rx transitions midway between ticks so sample points sit mid-bit.
  task automatic align();
    hold(1);
    while (cyc % 10 != 5) hold(1);
  endtask

  task automatic send(input logic [7:0] d, input logic pbit, input int gap_ticks, output int t0);
    t0 = cyc;
    ifc.rx = 1'b0;
    hold(160);
    for (int i = 0; i < 8; i++) begin
      ifc.rx = d[i];
      hold(160);
    end
`ifdef UART_RX_PARITY_EN
    ifc.rx = pbit;
    hold(160);
`else
    if (pbit) ifc.rx = 1'b1;
`endif
    ifc.rx = 1'b1;
    hold(160 + gap_ticks * 10);
  endtask

  task automatic expect_frame(input string name, input logic [7:0] d, input logic perr,
                              input int t0, output int pc);
    rec_t r;
    int   k = 0;
    pc = 0;
    while (rcv.size() == 0 && k < 2000) begin
      hold(1);
      k++;
    end
    if (rcv.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: no rx_done_tick within budget", name);
    end else begin
      r  = rcv.pop_front();
      pc = r.cyc;
      chk({name, " dout"}, int'(r.d), int'(d));
      chk_range({name, " latency"}, r.cyc - t0, LAT_LO, LAT_HI);
`ifdef UART_RX_PARITY_EN
      chk({name, " parity_err"}, int'(r.perr), int'(perr));
`else
      if (perr) hold(0);
`endif
    end
  endtask

  vec_t vecs[9];

  initial begin
    int t0;
    int pc;
    int k;
    logic [7:0] d;
    logic       pbit;

    vecs[0] = '{8'hA5, 1'b0, 20, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b0,  0, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 20, 8'hFF, 1'b0};
    vecs[3] = '{8'h01, 1'b1,  5, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 1'b1,  5, 8'h80, 1'b0};
    vecs[5] = '{8'h55, 1'b0,  0, 8'h55, 1'b0};
    vecs[6] = '{8'hAA, 1'b0, 10, 8'hAA, 1'b0};
    vecs[7] = '{8'h07, 1'b1, 10, 8'h07, 1'b0};
    vecs[8] = '{8'h07, 1'b0, 10, 8'h07, 1'b1};

    ifc.rx = 1'b1;
    reset  = 1'b1;
    hold(5);
    chk("reset dout", int'(ifc.dout), 0);
    chk("reset rx_done_tick", int'(ifc.rx_done_tick), 0);
    chk("reset dout sb32", int'(ifc32.dout), 0);
`ifdef UART_RX_PARITY_EN
    chk("reset parity_err", int'(ifc.parity_err), 0);
`endif
    reset = 1'b0;
    hold(20);
    align();

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].d, vecs[i].pbit, vecs[i].gap, t0);
      expect_frame($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_perr, t0, pc);
    end

    // False start: 3 ticks low, then idle; nothing may complete.
    ifc.rx = 1'b0;
    hold(30);
    ifc.rx = 1'b1;
    hold(3000);
    chk("false start pulses", rcv.size(), 0);
    chk("false start dout", int'(ifc.dout), 8'h07);
    send(8'hC3, 1'b0, 20, t0);
    expect_frame("after false start", 8'hC3, 1'b0, t0, pc);

    // Reset in the middle of bit 4 of 0x3C.
    d = 8'h3C;
    ifc.rx = 1'b0;
    hold(160);
    for (int i = 0; i < 4; i++) begin
      ifc.rx = d[i];
      hold(160);
    end
    ifc.rx = d[4];
    hold(80);
    reset  = 1'b1;
    ifc.rx = 1'b1;
    hold(10);
    reset = 1'b0;
    hold(3000);
    chk("mid-frame reset pulses", rcv.size(), 0);
    chk("mid-frame reset dout", int'(ifc.dout), 0);
    align();
    send(8'h81, 1'b0, 20, t0);
    expect_frame("after reset", 8'h81, 1'b0, t0, pc);

    // Two stop bits: the SB_TICK=32 instance finishes exactly 16 ticks later.
    hold(2000);
    align();
    q32_cyc.delete();
    q32_d.delete();
    send(8'h5A, 1'b0, 40, t0);
    expect_frame("sb16 5A", 8'h5A, 1'b0, t0, pc);
    k = 0;
    while (q32_cyc.size() == 0 && k < 2000) begin
      hold(1);
      k++;
    end
    if (q32_cyc.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL sb32 pulse: none within budget");
    end else begin
      chk("sb32 extra delay", q32_cyc[0] - pc, 160);
      chk("sb32 dout", int'(q32_d[0]), 8'h5A);
    end

    // Random frames against the frame-level model: dout is the byte, parity_err is odd overall parity.
    for (int i = 0; i < 16; i++) begin
      d    = 8'($urandom_range(0, 255));
      pbit = (PB != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(d, pbit, $urandom_range(0, 12), t0);
      expect_frame($sformatf("rand%0d", i), d, (^d) ^ pbit, t0, pc);
    end

    hold(200);
    chk("pulse width violations", wide, 0);
    chk("dout hold violations", hold_viol, 0);
    chk("unexpected pulses", rcv.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
